// File: rtl/bp_pkg.sv
// Shared branch-prediction definitions: 2-bit direction counter encodings
// plus the values used at reset and on allocation.
package bp_pkg;

    localparam logic [1:0] CNT_SNT = 2'b00;
    localparam logic [1:0] CNT_WNT = 2'b01;
    localparam logic [1:0] CNT_WT  = 2'b10;
    localparam logic [1:0] CNT_ST  = 2'b11;

    localparam logic [1:0] CNT_RST       = CNT_WNT;
    localparam logic [1:0] CNT_ALLOC_BR  = CNT_WT;
    localparam logic [1:0] CNT_ALLOC_JMP = CNT_ST;

endpackage

// File: rtl/sat_cnt2.sv
// Next-state logic for one 2-bit saturating direction counter.
module sat_cnt2
    import bp_pkg::*;
(
    input  logic [1:0] cnt,
    input  logic       inc,
    output logic [1:0] cnt_next
);

    always_comb begin
        cnt_next = cnt;
        if (inc) begin
            if (cnt != CNT_ST) cnt_next = cnt + 2'd1;
        end else begin
            if (cnt != CNT_SNT) cnt_next = cnt - 2'd1;
        end
    end

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped BTB with 2-bit direction counters, combinational lookup.
// Optional BTB_STATS_EN adds branch / mispredict event counters.
module btb_predictor
    import bp_pkg::*;
#(
    parameter int IDX_BITS = 4,
    parameter int TAG_BITS = 30 - IDX_BITS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC,
    output logic        hit,
    output logic        taken,
    output logic [31:0] pred_PC,
    input  logic        upd_valid,
    input  logic [31:0] upd_PC,
    input  logic        upd_taken,
    input  logic        upd_jump,
    input  logic [31:0] upd_target,
    input  logic        upd_mispred
`ifdef BTB_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispred
`endif
);

    localparam int N = 2 ** IDX_BITS;

    logic [N-1:0]          valid_q;
    logic [TAG_BITS-1:0]   tag_q    [N];
    logic [31:0]           target_q [N];
    logic [1:0]            cnt_q    [N];

    logic [IDX_BITS-1:0] lidx, uidx;
    logic [TAG_BITS-1:0] ltag, utag;
    logic                lmatch, umatch;
    logic                alloc, train, we_tgt;
    logic [1:0]          cnt_nxt, cnt_d;

    assign lidx = PC[IDX_BITS+1:2];
    assign ltag = PC[31:IDX_BITS+2];
    assign uidx = upd_PC[IDX_BITS+1:2];
    assign utag = upd_PC[31:IDX_BITS+2];

    // Reset masks the outputs even though the array may still hold data.
    assign lmatch  = !rst && valid_q[lidx] && (tag_q[lidx] == ltag);
    assign hit     = lmatch;
    assign taken   = lmatch && cnt_q[lidx][1];
    assign pred_PC = lmatch ? target_q[lidx] : 32'd0;

    assign umatch = valid_q[uidx] && (tag_q[uidx] == utag);

    sat_cnt2 u_cnt (
        .cnt      (cnt_q[uidx]),
        .inc      (upd_taken),
        .cnt_next (cnt_nxt)
    );

    always_comb begin
        alloc  = upd_valid && !umatch && upd_taken;
        train  = upd_valid && umatch;
        we_tgt = alloc || (train && upd_taken);
        cnt_d  = cnt_nxt;
        if (alloc) cnt_d = upd_jump ? CNT_ALLOC_JMP : CNT_ALLOC_BR;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < N; i++) cnt_q[i] <= CNT_RST;
        end else begin
            if (alloc) begin
                valid_q[uidx] <= 1'b1;
                tag_q[uidx]   <= utag;
            end
            if (we_tgt)         target_q[uidx] <= upd_target;
            if (alloc || train) cnt_q[uidx]    <= cnt_d;
        end
    end

`ifdef BTB_STATS_EN
    logic [31:0] br_q, br_d, mp_q, mp_d;

    always_comb begin
        br_d = br_q;
        mp_d = mp_q;
        if (upd_valid) br_d = br_q + 32'd1;
        if (upd_valid && upd_mispred) mp_d = mp_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            br_q <= '0;
            mp_q <= '0;
        end else begin
            br_q <= br_d;
            mp_q <= mp_d;
        end
    end

    assign stat_branches = br_q;
    assign stat_mispred  = mp_q;
`else
    logic unused_mispred;
    assign unused_mispred = upd_mispred;
`endif

    logic unused_lsb;
    assign unused_lsb = ^{PC[1:0], upd_PC[1:0]};

endmodule

// File: tb/tb_btb_predictor.sv
// Directed self-checking bench for btb_predictor (IDX_BITS = 4).
// Stat checks compile only when BTB_STATS_EN is defined.
module tb_btb_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PC;
    logic        hit, taken;
    logic [31:0] pred_PC;
    logic        upd_valid, upd_taken, upd_jump, upd_mispred;
    logic [31:0] upd_PC, upd_target;
`ifdef BTB_STATS_EN
    logic [31:0] stat_branches, stat_mispred;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    btb_predictor #(.IDX_BITS(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .PC          (PC),
        .hit         (hit),
        .taken       (taken),
        .pred_PC     (pred_PC),
        .upd_valid   (upd_valid),
        .upd_PC      (upd_PC),
        .upd_taken   (upd_taken),
        .upd_jump    (upd_jump),
        .upd_target  (upd_target),
        .upd_mispred (upd_mispred)
`ifdef BTB_STATS_EN
        ,
        .stat_branches (stat_branches),
        .stat_mispred  (stat_mispred)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic look(input string tag, input logic [31:0] pc,
                        input logic eh, input logic et,
                        input logic [31:0] ep);
        PC = pc;
        #1;
        chk({tag, ".hit"}, {31'd0, hit}, {31'd0, eh});
        chk({tag, ".tkn"}, {31'd0, taken}, {31'd0, et});
        chk({tag, ".pc"}, pred_PC, ep);
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk,
                       input logic jmp, input logic [31:0] tgt,
                       input logic mp);
        upd_valid   = 1'b1;
        upd_PC      = pc;
        upd_taken   = tk;
        upd_jump    = jmp;
        upd_target  = tgt;
        upd_mispred = mp;
        step();
        upd_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        PC = 32'h40;
        upd_valid = 1'b1;
        upd_PC = 32'h40;
        upd_taken = 1'b1;
        upd_jump = 1'b1;
        upd_target = 32'h1234;
        upd_mispred = 1'b1;
        repeat (2) step();
        look("rst_hold", 32'h40, 1'b0, 1'b0, 32'h0);
`ifdef BTB_STATS_EN
        chk("rst_br", stat_branches, 32'd0);
        chk("rst_mp", stat_mispred, 32'd0);
`endif
        upd_valid = 1'b0;
        rst = 1'b0;
        look("rst_drop", 32'h40, 1'b0, 1'b0, 32'h0);

        // Same-cycle allocate vs lookup: old contents this cycle.
        upd_valid = 1'b1;
        upd_PC = 32'h100;
        upd_taken = 1'b1;
        upd_jump = 1'b0;
        upd_target = 32'h80;
        upd_mispred = 1'b0;
        look("haz_now", 32'h100, 1'b0, 1'b0, 32'h0);
        step();
        upd_valid = 1'b0;
        look("alloc_br", 32'h100, 1'b1, 1'b1, 32'h80);

        upd(32'h100, 1'b0, 1'b0, 32'hdead, 1'b1);
        look("nt1", 32'h100, 1'b1, 1'b0, 32'h80);
        upd(32'h100, 1'b0, 1'b0, 32'hdead, 1'b0);
        upd(32'h100, 1'b0, 1'b0, 32'hdead, 1'b0);
        look("sat_lo", 32'h100, 1'b1, 1'b0, 32'h80);
        upd(32'h100, 1'b1, 1'b0, 32'h84, 1'b1);
        look("inc01", 32'h100, 1'b1, 1'b0, 32'h84);
        upd(32'h100, 1'b1, 1'b0, 32'h84, 1'b0);
        look("inc10", 32'h100, 1'b1, 1'b1, 32'h84);
        upd(32'h100, 1'b1, 1'b0, 32'h84, 1'b0);
        upd(32'h100, 1'b1, 1'b0, 32'h84, 1'b0);
        upd(32'h100, 1'b0, 1'b0, 32'h84, 1'b1);
        look("sat_hi", 32'h100, 1'b1, 1'b1, 32'h84);

        upd(32'h200, 1'b1, 1'b1, 32'h400, 1'b1);
        look("jmp", 32'h200, 1'b1, 1'b1, 32'h400);
        look("jmp_evict", 32'h100, 1'b0, 1'b0, 32'h0);
        upd(32'h200, 1'b0, 1'b0, 32'h0, 1'b0);
        look("jmp_nt", 32'h200, 1'b1, 1'b1, 32'h400);

        upd(32'h100, 1'b1, 1'b0, 32'h80, 1'b0);
        look("realloc", 32'h100, 1'b1, 1'b1, 32'h80);
        upd(32'h140, 1'b1, 1'b0, 32'h300, 1'b1);
        look("alias_old", 32'h100, 1'b0, 1'b0, 32'h0);
        look("alias_new", 32'h140, 1'b1, 1'b1, 32'h300);
        upd(32'h180, 1'b0, 1'b0, 32'h999, 1'b0);
        look("nt_miss", 32'h140, 1'b1, 1'b1, 32'h300);
        look("nt_noalloc", 32'h180, 1'b0, 1'b0, 32'h0);

        upd(32'h104, 1'b1, 1'b0, 32'h500, 1'b0);
        look("idx1_lsb", 32'h106, 1'b1, 1'b1, 32'h500);
        look("idx0_kept", 32'h140, 1'b1, 1'b1, 32'h300);

        upd_valid = 1'b0;
        upd_PC = 32'h140;
        upd_taken = 1'b1;
        upd_target = 32'h777;
        step();
        look("no_strobe", 32'h140, 1'b1, 1'b1, 32'h300);

        rst = 1'b1;
        look("rst_mask", 32'h140, 1'b0, 1'b0, 32'h0);
        step();
        rst = 1'b0;
        look("rst_lost", 32'h140, 1'b0, 1'b0, 32'h0);
        look("rst_lost1", 32'h104, 1'b0, 1'b0, 32'h0);

`ifdef BTB_STATS_EN
        for (int i = 0; i < 10; i++)
            upd(32'h300 + 32'(i * 4), i[0], 1'b0, 32'h10,
                (i == 1) || (i == 4) || (i == 8));
        chk("st_br", stat_branches, 32'd10);
        chk("st_mp", stat_mispred, 32'd3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("st_br_rst", stat_branches, 32'd0);
        chk("st_mp_rst", stat_mispred, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/btb_predictor.md
# btb_predictor

Direct-mapped branch target buffer with per-entry 2-bit saturating direction counters. Sits beside the fetch stage: answers `hit`, `taken` and `pred_PC` combinationally for the current fetch `PC`, which selects `pred_PC` over `PC+4` when `hit & taken`. The execute stage writes the resolved outcome of every branch or jump back through the update port.

## Interface
Parameters:
- `IDX_BITS`, 4: index width; `2**IDX_BITS` entries.
- `TAG_BITS`, `30-IDX_BITS`: tag width, `PC[31:IDX_BITS+2]`.

Ports:
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `PC`  in  32  current fetch address.
- `hit`  out  1  valid entry whose tag matches `PC`.
- `taken`  out  1  MSB of the matched entry's counter; 0 when `!hit`.
- `pred_PC`  out  32  stored target of the matched entry; 0 when `!hit`.
- `upd_valid`  in  1  execute stage resolved a control-transfer instruction this cycle.
- `upd_PC`  in  32  address of the resolved instruction.
- `upd_taken`  in  1  actual direction; always 1 for jal/jalr.
- `upd_jump`  in  1  instruction is an unconditional jal/jalr.
- `upd_target`  in  32  resolved target address; bit 0 already cleared for jalr.
- `upd_mispred`  in  1  fetch path was wrong; used only by the statistics option.
- `stat_branches`  out  32  present only with `BTB_STATS_EN`.
- `stat_mispred`  out  32  present only with `BTB_STATS_EN`.

## Operation
- Per-entry state: `valid`, `tag[TAG_BITS]`, `target[32]`, `cnt[2]`.
- Entry index is `PC[IDX_BITS+1:2]`. `PC[1:0]` is ignored everywhere.
- **Lookup** is purely combinational from `PC` and the current array contents.
- **Update** is applied when `upd_valid` is high. Let `e` be the entry at `upd_PC`'s index and `m` = `e.valid` and tag match.
  - `m` and `upd_taken`: `cnt` increments, saturating at 11; `target` is overwritten with `upd_target`.
  - `m` and `!upd_taken`: `cnt` decrements, saturating at 00; `target` is unchanged. The entry stays valid.
  - `!m` and `upd_taken`: allocate or replace. Set `valid=1`, `tag` and `target` from the update, and `cnt` = 11 if `upd_jump`, else 10.
  - `!m` and `!upd_taken`: no change. Not-taken branches are never allocated.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Aliasing between different PCs is resolved by the tag only. A conflicting taken update evicts the old entry unconditionally.
- Non-branch instructions never drive `upd_valid`. The block does not decode opcodes.

## Timing
- Lookup latency is 0 cycles; outputs depend only on `PC` and the registered state.
- An update sampled at edge N is visible to lookups from edge N onward, i.e. in the cycle after `upd_valid`.
- Same-cycle lookup and update to the same index: the lookup returns the pre-update contents. There is no write-through bypass.
- Reset:
  - While `rst` is high, `hit`=0, `taken`=0 and `pred_PC`=0, regardless of array contents.
  - At the reset edge every `valid` clears and every `cnt` goes to 01. `tag` and `target` need no reset.
  - Stat counters clear to 0.
  - An update presented in a reset cycle is discarded.
  - Reset mid-operation loses all training.
- No handshake and no stall. `upd_valid` is a single-cycle strobe, and back-to-back updates are legal every cycle, including to the same index.

## Configuration
- `BTB_STATS_EN` defined:
  - `stat_branches` increments on every `upd_valid`.
  - `stat_mispred` increments on `upd_valid & upd_mispred`.
  - Both are 32-bit, wrap at 2^32, and clear on `rst`.
- `BTB_STATS_EN` undefined: both ports and their counters are absent. Prediction behaviour is identical in both builds.

## Structure
- Shared package `bp_pkg`:
  - counter encodings `CNT_SNT`, `CNT_WNT`, `CNT_WT`, `CNT_ST`;
  - reset counter value `CNT_RST` = `CNT_WNT`;
  - allocation values `CNT_ALLOC_BR` = `CNT_WT` and `CNT_ALLOC_JMP` = `CNT_ST`.
- Sub-module `sat_cnt2`: combinational next-state for one 2-bit counter (inputs `cnt`, `inc`; output `cnt_next`), instantiated once on the update path.
- Arrays are flop-based, with no SRAM macro.

## Test plan
- **Reset behaviour:** assert `rst` for 2 cycles, then drive `PC`=0x0000_0040 -> `hit`=0, `taken`=0, `pred_PC`=0. Stat counters read 0.
- **Branch allocation and training:**
  - Update `upd_PC`=0x100, taken, target 0x80 -> next cycle, `PC`=0x100 gives `hit`=1, `taken`=1, `pred_PC`=0x80.
  - One not-taken update -> `taken`=0, `hit`=1.
  - A further not-taken update -> `cnt` saturates at 00.
- **Jump allocation:** jal update at 0x200 -> 0x400 -> `cnt`=11. One not-taken update still leaves `taken`=1.
- **Alias eviction and tag check:** with `IDX_BITS`=4, the entry at 0x100 exists. A taken update at 0x140 (same index) evicts it -> `PC`=0x100 gives `hit`=0 and `PC`=0x140 gives `hit`=1. A not-taken update at 0x180 leaves the entry unchanged.
- **Same-cycle hazard:** lookup 0x100 while updating 0x100 (allocate) -> this cycle `hit`=0, next cycle `hit`=1.
- **Statistics (`BTB_STATS_EN`):** 10 updates, 3 with `upd_mispred` -> `stat_branches`=10, `stat_mispred`=3. Reset mid-run -> both read 0.
